mem_access_unit: RTL and testbench

Multicycle load/store initiator between the datapath and `d_mem`. Accepts one byte/halfword/word load or store request, drives `address`/`writeData`/`memRead`/`memWrite` toward the word-wide data memory, and returns sign- or zero-extended load data. Sub-word stores use read-modify-write so `d_mem` stays strictly word-wide. Misaligned requests are flagged and never reach memory.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/lane_align.sv | 40 ++++
 rtl/mem_access_unit.sv | 115 +++++++++++
 tb/tb_mem_access_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the load/store initiator.
package mem_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  // Access size; unlisted op codes behave as word accesses.
  function automatic size_e size_of(input logic [2:0] op);
    case (op)
      OP_B, OP_BU: size_of = SZ_B;
      OP_H, OP_HU: size_of = SZ_H;
      default:     size_of = SZ_W;
    endcase
  endfunction

  // Halfwords need an even address, words a 4-byte-aligned one.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] a);
    case (size_of(op))
      SZ_B:    is_misaligned = 1'b0;
      SZ_H:    is_misaligned = a[0];
      default: is_misaligned = (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lane_align.sv
// Little-endian byte-lane steering: store merge and load extract/extend.
module lane_align
  import mem_pkg::*;
(
  input  logic [31:0] merge_word_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_word_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  op_i,
  output logic [31:0] merged_o,
  output logic [31:0] loaded_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Replace the addressed lane(s) of the captured word with store data.
  always_comb begin
    merged_o = merge_word_i;
    case (size_of(op_i))
      SZ_B:    merged_o[{addr_i, 3'b000} +: 8]        = store_data_i[7:0];
      SZ_H:    merged_o[{addr_i[1], 4'b0000} +: 16]   = store_data_i[15:0];
      default: merged_o = store_data_i;
    endcase
  end

  // Select the addressed lane of the read word and extend it.
  always_comb begin
    ld_byte = load_word_i[{addr_i, 3'b000} +: 8];
    ld_half = load_word_i[{addr_i[1], 4'b0000} +: 16];
    case (op_i)
      OP_B:    loaded_o = {{24{ld_byte[7]}}, ld_byte};
      OP_BU:   loaded_o = {24'h000000, ld_byte};
      OP_H:    loaded_o = {{16{ld_half[15]}}, ld_half};
      OP_HU:   loaded_o = {16'h0000, ld_half};
      default: loaded_o = load_word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multicycle byte/half/word load/store initiator toward a word-wide d_mem.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        isStore,
  input  logic [2:0]  op,
  input  logic [31:0] cpuAddr,
  input  logic [31:0] storeData,
  input  logic [31:0] readData,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output logic [31:0] loadData,
  output logic [31:0] address,
  output logic [31:0] writeData,
  output logic        memRead,
  output logic        memWrite
);

  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          is_store_q, mis_q;
  logic [2:0]    op_q;
  logic [31:0]   addr_q, sdata_q, word_q, load_data_q;
  logic          accept, rd_last;
  logic [31:0]   merged, extracted;

  lane_align u_lane_align (
    .merge_word_i (word_q),
    .store_data_i (sdata_q),
    .load_word_i  (readData),
    .addr_i       (addr_q[1:0]),
    .op_i         (op_q),
    .merged_o     (merged),
    .loaded_o     (extracted)
  );

  // Next-state logic and wait counter.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    accept  = 1'b0;
    rd_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (is_misaligned(op, cpuAddr[1:0]))          state_d = DONE;
          else if (!isStore || size_of(op) != SZ_W)     state_d = RD;
          else                                          state_d = WR;
        end
      end
      RD: begin
        if (wcnt_q == LAST) begin
          rd_last = 1'b1;
          wcnt_d  = '0;
          state_d = is_store_q ? WR : DONE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, request capture and read-word capture.
  // Load extraction is taken from readData on the last RD edge so loadData is already valid in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      is_store_q  <= 1'b0;
      mis_q       <= 1'b0;
      op_q        <= '0;
      addr_q      <= '0;
      sdata_q     <= '0;
      word_q      <= '0;
      load_data_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (accept) begin
        is_store_q <= isStore;
        mis_q      <= is_misaligned(op, cpuAddr[1:0]);
        op_q       <= op;
        addr_q     <= cpuAddr;
        sdata_q    <= storeData;
      end
      if (rd_last) begin
        word_q <= readData;
        if (!is_store_q) load_data_q <= extracted;
      end
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign misaligned = (state_q == DONE) && mis_q;
  assign memRead    = (state_q == RD);
  assign memWrite   = (state_q == WR);
  assign address    = {2'b00, addr_q[31:2]};
  assign writeData  = merged;
  assign loadData   = load_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a small word memory.
module tb_mem_access_unit;

  localparam int unsigned WAIT = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        isStore = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] cpuAddr = '0;
  logic [31:0] storeData = '0;
  logic [31:0] readData;
  logic        busy, done, misaligned, memRead, memWrite;
  logic [31:0] loadData, address, writeData;

  logic [31:0] mem [0:15];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_unit #(.WAIT_CYCLES(WAIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .isStore    (isStore),
    .op         (op),
    .cpuAddr    (cpuAddr),
    .storeData  (storeData),
    .readData   (readData),
    .busy       (busy),
    .done       (done),
    .misaligned (misaligned),
    .loadData   (loadData),
    .address    (address),
    .writeData  (writeData),
    .memRead    (memRead),
    .memWrite   (memWrite)
  );

  always #5 clk = ~clk;

  // Combinational-read, synchronous-write word memory; preload port for the bench.
  assign readData = mem[address[3:0]];
  always @(posedge clk) begin
    if (pl_en)         mem[pl_idx] <= pl_val;
    else if (memWrite) mem[address[3:0]] <= writeData;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Issue one request, then watch up to 20 cycles for done.
  task automatic run_req(input logic st, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output int nrd,
                         output int nwr, output logic [31:0] wd, output logic mis,
                         output logic [31:0] ld, output logic [31:0] rd_addr,
                         output int both);
    @(negedge clk);
    start = 1'b1; isStore = st; op = o; cpuAddr = a; storeData = d;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; nrd = 0; nwr = 0; wd = '0; mis = 1'b0; ld = '0; rd_addr = '1; both = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (memRead) begin nrd++; rd_addr = address; end
      if (memWrite) begin nwr++; wd = writeData; end
      if (memRead && memWrite) both++;
      if (done) begin lat = k; mis = misaligned; ld = loadData; break; end
    end
  endtask

  int          lat, nrd, nwr, both;
  logic [31:0] wd, ld, ra;
  logic        mis;
  logic [7:0]  done_vec, rd_vec, wr_vec;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mis", 32'(misaligned), 32'd0);
    check("rst_rdwr", {30'd0, memRead, memWrite}, 32'd0);
    check("rst_addr", address, 32'd0);
    check("rst_wdata", writeData, 32'd0);
    check("rst_ldata", loadData, 32'd0);
    reset = 1'b0;

    // LW aligned
    preload(4'd4, 32'hDEAD_BEEF);
    run_req(1'b0, 3'b010, 32'h10, 32'h0, lat, nrd, nwr, wd, mis, ld, ra, both);
    check("lw_lat", 32'(lat), 32'd2);
    check("lw_nrd", 32'(nrd), 32'd1);
    check("lw_nwr", 32'(nwr), 32'd0);
    check("lw_addr", ra, 32'd4);
    check("lw_data", ld, 32'hDEAD_BEEF);
    check("lw_mis", 32'(mis), 32'd0);

    // Byte/half loads with sign and zero extension
    preload(4'd4, 32'h80FF_7F01);
    run_req(1'b0, 3'b000, 32'h13, 32'h0, lat, nrd, nwr, wd, mis, ld, ra, both);
    check("lb_data", ld, 32'hFFFF_FF80);
    run_req(1'b0, 3'b100, 32'h13, 32'h0, lat, nrd, nwr, wd, mis, ld, ra, both);
    check("lbu_data", ld, 32'h0000_0080);
    run_req(1'b0, 3'b000, 32'h11, 32'h0, lat, nrd, nwr, wd, mis, ld, ra, both);
    check("lb1_data", ld, 32'h0000_007F);
    run_req(1'b0, 3'b001, 32'h12, 32'h0, lat, nrd, nwr, wd, mis, ld, ra, both);
    check("lh_data", ld, 32'hFFFF_80FF);
    run_req(1'b0, 3'b101, 32'h10, 32'h0, lat, nrd, nwr, wd, mis, ld, ra, both);
    check("lhu_data", ld, 32'h0000_7F01);

    // SB read-modify-write
    preload(4'd4, 32'h1122_3344);
    run_req(1'b1, 3'b000, 32'h11, 32'h1234_56AA, lat, nrd, nwr, wd, mis, ld, ra, both);
    check("sb_lat", 32'(lat), 32'd3);
    check("sb_nrd", 32'(nrd), 32'd1);
    check("sb_nwr", 32'(nwr), 32'd1);
    check("sb_wdata", wd, 32'h1122_AA44);
    check("sb_both", 32'(both), 32'd0);
    check("sb_mem", mem[4], 32'h1122_AA44);
    check("sb_ld_held", ld, 32'h0000_7F01);

    // Misaligned word store and halfword load
    run_req(1'b1, 3'b010, 32'h06, 32'hFFFF_FFFF, lat, nrd, nwr, wd, mis, ld, ra, both);
    check("sw_mis_lat", 32'(lat), 32'd1);
    check("sw_mis_flag", 32'(mis), 32'd1);
    check("sw_mis_rdwr", 32'(nrd + nwr), 32'd0);
    run_req(1'b0, 3'b001, 32'h11, 32'h0, lat, nrd, nwr, wd, mis, ld, ra, both);
    check("lh_mis_lat", 32'(lat), 32'd1);
    check("lh_mis_flag", 32'(mis), 32'd1);

    // Aligned SH at offset 2
    preload(4'd0, 32'hCAFE_F00D);
    run_req(1'b1, 3'b001, 32'h02, 32'h0000_BEEF, lat, nrd, nwr, wd, mis, ld, ra, both);
    check("sh_lat", 32'(lat), 32'd3);
    check("sh_mis", 32'(mis), 32'd0);
    check("sh_wdata", wd, 32'hBEEF_F00D);

    // Word store
    run_req(1'b1, 3'b010, 32'h20, 32'h0102_0304, lat, nrd, nwr, wd, mis, ld, ra, both);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_nrd", 32'(nrd), 32'd0);
    check("sw_nwr", 32'(nwr), 32'd1);
    check("sw_mem", mem[8], 32'h0102_0304);

    // start pulsed during RD is ignored
    preload(4'd4, 32'hDEAD_BEEF);
    @(negedge clk);
    start = 1'b1; isStore = 1'b0; op = 3'b010; cpuAddr = 32'h10;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; isStore = 1'b1; op = 3'b010; cpuAddr = 32'h24; storeData = 32'h5555_5555;
    @(posedge clk); #1;
    start = 1'b0;
    done_vec = '0; wr_vec = '0;
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      done_vec[k] = done;
      wr_vec[k]   = memWrite;
    end
    check("rdpulse_done", {24'd0, done_vec}, 32'h0000_0004);
    check("rdpulse_nowr", {24'd0, wr_vec}, 32'd0);
    check("rdpulse_mem9", mem[9], 32'd0);

    // start held high through a LW: re-accepted in the cycle after DONE
    @(negedge clk);
    start = 1'b1; isStore = 1'b0; op = 3'b010; cpuAddr = 32'h10;
    @(posedge clk); #1;
    done_vec = '0; rd_vec = '0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      done_vec[k] = done;
      rd_vec[k]   = memRead;
      if (k == 4) start = 1'b0;
    end
    check("hold_done", {24'd0, done_vec}, 32'h0000_0024);
    check("hold_rd", {24'd0, rd_vec}, 32'h0000_0012);

    // reset during RD of a sub-word store
    preload(4'd4, 32'h1122_3344);
    @(negedge clk);
    start = 1'b1; isStore = 1'b1; op = 3'b000; cpuAddr = 32'h11; storeData = 32'h0000_00AA;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("rstmid_inrd", 32'(memRead), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rstmid_out", {busy, done, misaligned, memRead, memWrite}, 32'd0);
    check("rstmid_addr", address, 32'd0);
    check("rstmid_wdata", writeData, 32'd0);
    check("rstmid_ldata", loadData, 32'd0);
    wr_vec = '0; done_vec = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      wr_vec[k]   = memWrite;
      done_vec[k] = done;
    end
    check("rstmid_nowr", {24'd0, wr_vec}, 32'd0);
    check("rstmid_nodone", {24'd0, done_vec}, 32'd0);
    check("rstmid_mem", mem[4], 32'h1122_3344);
    run_req(1'b0, 3'b010, 32'h10, 32'h0, lat, nrd, nwr, wd, mis, ld, ra, both);
    check("rstmid_lw_lat", 32'(lat), 32'd2);
    check("rstmid_lw_data", ld, 32'h1122_3344);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
